// File: rtl/vga_pkg.sv
// 800x600@60 raster timing constants and the shared counter type.
// Pure declarations: no logic, no latency.
package vga_pkg;

    localparam int HOR_PIXELS      = 800;
    localparam int HOR_FRONT_PORCH = 40;
    localparam int HOR_SYNC_TIME   = 128;
    localparam int HOR_TOTAL       = 1056;

    localparam int VER_PIXELS      = 600;
    localparam int VER_FRONT_PORCH = 1;
    localparam int VER_SYNC_TIME   = 4;
    localparam int VER_TOTAL       = 628;

    localparam int HOR_SYNC_START  = HOR_PIXELS + HOR_FRONT_PORCH;
    localparam int VER_SYNC_START  = VER_PIXELS + VER_FRONT_PORCH;

    typedef logic [10:0] vga_cnt_t;

endpackage

// File: rtl/vga_if.sv
// Pixel-stream link between raster stages: position, syncs, blanking and colour.
// No handshake; the stream advances with the shared pixel clock.
interface vga_if;
    import vga_pkg::*;

    vga_cnt_t    hcount;
    vga_cnt_t    vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter with blank/sync flags decoded from the next count.
// Count and flags are registered together, so they never skew; wrap is the terminal count.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int   TOTAL      = HOR_TOTAL,
    parameter int   ACTIVE     = HOR_PIXELS,
    parameter int   SYNC_START = HOR_SYNC_START,
    parameter int   SYNC_LEN   = HOR_SYNC_TIME,
    parameter logic POL        = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     step,
    output vga_cnt_t cnt,
    output logic     blnk,
    output logic     sync,
    output logic     wrap
);

    localparam vga_cnt_t LAST       = vga_cnt_t'(TOTAL - 1);
    localparam vga_cnt_t ACT        = vga_cnt_t'(ACTIVE);
    localparam vga_cnt_t SYNC_FIRST = vga_cnt_t'(SYNC_START);
    localparam vga_cnt_t SYNC_LAST  = vga_cnt_t'(SYNC_START + SYNC_LEN - 1);
    localparam vga_cnt_t ONE        = vga_cnt_t'(1);

    vga_cnt_t cnt_q, cnt_d;
    logic     blnk_q, blnk_d;
    logic     sync_q, sync_d;

    always_comb begin
        cnt_d = cnt_q;
        if (step) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + ONE;
        end
        blnk_d = (cnt_d >= ACT);
        sync_d = ((cnt_d >= SYNC_FIRST) && (cnt_d <= SYNC_LAST)) ? POL : ~POL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            blnk_q <= 1'b0;
            sync_q <= ~POL;
        end else begin
            cnt_q  <= cnt_d;
            blnk_q <= blnk_d;
            sync_q <= sync_d;
        end
    end

    assign cnt  = cnt_q;
    assign blnk = blnk_q;
    assign sync = sync_q;
    assign wrap = (cnt_q == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Source of the vga_if stream: raster counters, syncs, blanking and frame_start strobe.
// All outputs registered, flags aligned with counts; en=0 freezes everything.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter logic HSYNC_POL    = 1'b1,
    parameter logic VSYNC_POL    = 1'b1,
    parameter int   H_ACTIVE     = HOR_PIXELS,
    parameter int   H_SYNC_START = HOR_SYNC_START,
    parameter int   H_SYNC_LEN   = HOR_SYNC_TIME,
    parameter int   H_TOTAL      = HOR_TOTAL,
    parameter int   V_ACTIVE     = VER_PIXELS,
    parameter int   V_SYNC_START = VER_SYNC_START,
    parameter int   V_SYNC_LEN   = VER_SYNC_TIME,
    parameter int   V_TOTAL      = VER_TOTAL
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    vga_if.out   vga_out,
    output logic frame_start
);

    vga_cnt_t h_cnt, v_cnt;
    logic     h_blnk, v_blnk;
    logic     h_sync, v_sync;
    logic     h_wrap, v_wrap;
    logic     v_step;
    logic     frame_start_q, frame_start_d;

    assign v_step = en & h_wrap;

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (H_SYNC_START),
        .SYNC_LEN   (H_SYNC_LEN),
        .POL        (HSYNC_POL)
    ) u_hcnt (
        .clk  (clk),
        .rst  (rst),
        .step (en),
        .cnt  (h_cnt),
        .blnk (h_blnk),
        .sync (h_sync),
        .wrap (h_wrap)
    );

    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (V_SYNC_START),
        .SYNC_LEN   (V_SYNC_LEN),
        .POL        (VSYNC_POL)
    ) u_vcnt (
        .clk  (clk),
        .rst  (rst),
        .step (v_step),
        .cnt  (v_cnt),
        .blnk (v_blnk),
        .sync (v_sync),
        .wrap (v_wrap)
    );

    // Both axes at their terminal count: the coming edge lands on (0,0).
    assign frame_start_d = en & h_wrap & v_wrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= frame_start_d;
        end
    end

    assign frame_start    = frame_start_q;
    assign vga_out.hcount = h_cnt;
    assign vga_out.vcount = v_cnt;
    assign vga_out.hsync  = h_sync;
    assign vga_out.vsync  = v_sync;
    assign vga_out.hblnk  = h_blnk;
    assign vga_out.vblnk  = v_blnk;
    assign vga_out.rgb    = '0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full 800x600 timing for line-level behaviour (both polarities),
// plus a 24x10 raster instance (both polarities) for frame-level behaviour.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic fs_p, fs_n, fs_s, fs_sn;
    int   n_vec  = 0;
    int   n_miss = 0;

    vga_if vp ();
    vga_if vn ();
    vga_if vs ();
    vga_if vsn ();

    always #5 clk = ~clk;

    vga_timing_gen dut_p (
        .clk(clk), .rst(rst), .en(en), .vga_out(vp), .frame_start(fs_p)
    );

    vga_timing_gen #(.HSYNC_POL(1'b0), .VSYNC_POL(1'b0)) dut_n (
        .clk(clk), .rst(rst), .en(en), .vga_out(vn), .frame_start(fs_n)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_SYNC_START(18), .H_SYNC_LEN(4), .H_TOTAL(24),
        .V_ACTIVE(6),  .V_SYNC_START(7),  .V_SYNC_LEN(2), .V_TOTAL(10)
    ) dut_s (
        .clk(clk), .rst(rst), .en(en), .vga_out(vs), .frame_start(fs_s)
    );

    vga_timing_gen #(
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
        .H_ACTIVE(16), .H_SYNC_START(18), .H_SYNC_LEN(4), .H_TOTAL(24),
        .V_ACTIVE(6),  .V_SYNC_START(7),  .V_SYNC_LEN(2), .V_TOTAL(10)
    ) dut_sn (
        .clk(clk), .rst(rst), .en(en), .vga_out(vsn), .frame_start(fs_sn)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_full_h(input int h);
        int k;
        k = 0;
        while (int'(vp.hcount) != h && k < 1200) begin
            tick();
            k++;
        end
        chk("wait_full_h", int'(vp.hcount), h);
    endtask

    // Position encoded as v*100+h so one comparison covers both counters.
    function automatic int pos_s();
        return int'(vs.vcount) * 100 + int'(vs.hcount);
    endfunction

    task automatic wait_small(input int h, input int v);
        int k;
        k = 0;
        while (pos_s() != v * 100 + h && k < 400) begin
            tick();
            k++;
        end
        chk("wait_small", pos_s(), v * 100 + h);
    endtask

    initial begin
        int h;
        int hs_p, hs_n, hb, first_hb;
        int fs_seen, f0, f1, f2;
        int vs_hi, vb_hi, hb_hi, hs_hi, vsn_lo, hsn_lo, first_vs, first_vb;

        rst = 1'b1;
        en  = 1'b1;
        repeat (5) tick();

        // Reset state
        chk("rst_hcount", int'(vp.hcount), 0);
        chk("rst_vcount", int'(vp.vcount), 0);
        chk("rst_hblnk",  int'(vp.hblnk), 0);
        chk("rst_vblnk",  int'(vp.vblnk), 0);
        chk("rst_rgb",    int'(vp.rgb), 0);
        chk("rst_hsync",  int'(vp.hsync), 0);
        chk("rst_vsync",  int'(vp.vsync), 0);
        chk("rst_fs",     int'(fs_p), 0);
        chk("rst_hsync_n", int'(vn.hsync), 1);
        chk("rst_vsync_n", int'(vn.vsync), 1);
        chk("rst_vsync_sn", int'(vsn.vsync), 1);
        chk("rst_pos_s",  pos_s(), 0);

        rst = 1'b0;
        tick();
        chk("rel_hcount", int'(vp.hcount), 1);
        chk("rel_vcount", int'(vp.vcount), 0);
        chk("rel_hblnk",  int'(vp.hblnk), 0);
        chk("rel_fs",     int'(fs_p), 0);

        // One full line of the 800x600 raster
        hs_p = 0; hs_n = 0; hb = 0; first_hb = -1;
        for (int i = 0; i < 1100; i++) begin
            h = int'(vp.hcount);
            if (vp.hsync)  hs_p++;
            if (!vn.hsync) hs_n++;
            if (vp.hblnk)  hb++;
            if (vp.hblnk && first_hb < 0) first_hb = h;
            if (h == 799) chk("hblnk_799", int'(vp.hblnk), 0);
            if (h == 839) chk("hsync_839", int'(vp.hsync), 0);
            if (h == 840) begin
                chk("hsync_840",   int'(vp.hsync), 1);
                chk("hsync_n_840", int'(vn.hsync), 0);
            end
            if (h == 967) chk("hsync_967", int'(vp.hsync), 1);
            if (h == 968) chk("hsync_968", int'(vp.hsync), 0);
            if (h == 1055) break;
            tick();
        end
        chk("line_end_h",  int'(vp.hcount), 1055);
        chk("line_end_v",  int'(vp.vcount), 0);
        chk("hsync_cycles", hs_p, 128);
        chk("hsync_n_cycles", hs_n, 128);
        chk("hblnk_cycles", hb, 256);
        chk("hblnk_first", first_hb, 800);
        tick();
        chk("hwrap_h",     int'(vp.hcount), 0);
        chk("hwrap_v",     int'(vp.vcount), 1);
        chk("hwrap_hblnk", int'(vp.hblnk), 0);
        chk("hwrap_fs",    int'(fs_p), 0);

        // en toggling across a horizontal wrap
        wait_full_h(1054);
        tick();
        chk("en_pre_h", int'(vp.hcount), 1055);
        en = 1'b0;
        tick();
        chk("en_hold1_h", int'(vp.hcount), 1055);
        chk("en_hold1_v", int'(vp.vcount), 1);
        chk("en_hold1_hblnk", int'(vp.hblnk), 1);
        tick();
        chk("en_hold2_h", int'(vp.hcount), 1055);
        en = 1'b1;
        tick();
        chk("en_go_h", int'(vp.hcount), 0);
        chk("en_go_v", int'(vp.vcount), 2);

        // Reset pulse inside hsync, with en low
        wait_full_h(900);
        chk("mid_hsync", int'(vp.hsync), 1);
        rst = 1'b1;
        en  = 1'b0;
        tick();
        chk("midrst_h", int'(vp.hcount), 0);
        chk("midrst_v", int'(vp.vcount), 0);
        chk("midrst_hsync", int'(vp.hsync), 0);
        chk("midrst_hsync_n", int'(vn.hsync), 1);
        chk("midrst_hblnk", int'(vp.hblnk), 0);
        rst = 1'b0;
        en  = 1'b1;
        tick();
        chk("midrel_h", int'(vp.hcount), 1);

        // Small raster, restarted from (1,0) by the same release: two full frames
        fs_seen = 0; f0 = -1; f1 = -1; f2 = -1;
        vs_hi = 0; vb_hi = 0; hb_hi = 0; hs_hi = 0; vsn_lo = 0; hsn_lo = 0;
        first_vs = -1; first_vb = -1;
        for (int i = 0; i < 800; i++) begin
            if (fs_s) begin
                chk("fs_pos", pos_s(), 0);
                chk("fs_sn_align", int'(fs_sn), 1);
                if (fs_seen == 0) f0 = i;
                else if (fs_seen == 1) f1 = i;
                else f2 = i;
                fs_seen++;
            end
            if (fs_seen == 3) break;
            if (fs_seen >= 1) begin
                if (vs.vsync)   vs_hi++;
                if (vs.vblnk)   vb_hi++;
                if (vs.hblnk)   hb_hi++;
                if (vs.hsync)   hs_hi++;
                if (!vsn.vsync) vsn_lo++;
                if (!vsn.hsync) hsn_lo++;
                if (vs.vsync && first_vs < 0) first_vs = int'(vs.vcount);
                if (vs.vblnk && first_vb < 0) first_vb = int'(vs.vcount);
            end
            tick();
        end
        chk("fs_count", fs_seen, 3);
        chk("fs_first_idx", f0, 239);
        chk("frame1_len", f1 - f0, 240);
        chk("frame2_len", f2 - f1, 240);
        chk("vsync_cycles", vs_hi, 96);
        chk("vblnk_cycles", vb_hi, 192);
        chk("hblnk_s_cycles", hb_hi, 160);
        chk("hsync_s_cycles", hs_hi, 80);
        chk("vsync_n_cycles", vsn_lo, 96);
        chk("hsync_sn_cycles", hsn_lo, 80);
        chk("vsync_first_line", first_vs, 7);
        chk("vblnk_first_line", first_vb, 6);

        // en toggling across the frame wrap
        wait_small(22, 9);
        tick();
        chk("fw_pre_pos", pos_s(), 923);
        chk("fw_pre_fs", int'(fs_s), 0);
        chk("fw_pre_vblnk", int'(vs.vblnk), 1);
        en = 1'b0;
        tick();
        chk("fw_hold1_pos", pos_s(), 923);
        chk("fw_hold1_fs", int'(fs_s), 0);
        tick();
        chk("fw_hold2_pos", pos_s(), 923);
        chk("fw_hold2_fs", int'(fs_s), 0);
        en = 1'b1;
        tick();
        chk("fw_go_pos", pos_s(), 0);
        chk("fw_go_fs", int'(fs_s), 1);
        chk("fw_go_vblnk", int'(vs.vblnk), 0);
        chk("fw_go_hblnk", int'(vs.hblnk), 0);
        tick();
        chk("fw_after_fs", int'(fs_s), 0);
        chk("fw_after_pos", pos_s(), 1);

        // Reset pulse inside both syncs of the small raster
        wait_small(19, 7);
        chk("s_in_hsync", int'(vs.hsync), 1);
        chk("s_in_vsync", int'(vs.vsync), 1);
        chk("s_in_vsync_n", int'(vsn.vsync), 0);
        rst = 1'b1;
        en  = 1'b0;
        tick();
        chk("s_rst_pos", pos_s(), 0);
        chk("s_rst_hsync", int'(vs.hsync), 0);
        chk("s_rst_vsync", int'(vs.vsync), 0);
        chk("s_rst_vsync_n", int'(vsn.vsync), 1);
        chk("s_rst_fs", int'(fs_s), 0);
        rst = 1'b0;
        en  = 1'b1;
        tick();
        chk("s_rel_pos", pos_s(), 1);
        chk("s_rel_fs", int'(fs_s), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
